// File: rtl/posit_pkg.sv
// Shared posit definitions: decoded-field sizing, saturation bounds and
// magnitude constants used by the encoders and arithmetic units.
package posit_pkg;

    typedef enum logic [0:0] {NORMAL, WIDE} pd_type;

    function automatic int unsigned get_scale_width(pd_type t, int unsigned n, int unsigned es);
        int unsigned w;
        w = $clog2(n) + es + 2;
        return (t == WIDE) ? w + 2 : w;
    endfunction

    // NORMAL carries exactly the fraction bits a minimal-regime posit can hold.
    function automatic int unsigned get_fraction_width(pd_type t, int unsigned n,
                                                       int unsigned es);
        return (t == WIDE) ? 2 * n : n - es - 3;
    endfunction

    function automatic int get_max_scale(int unsigned n, int unsigned es);
        return int'((n - 2) << es);
    endfunction

    function automatic logic [63:0] get_maxpos(int unsigned n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] get_minpos();
        return 64'd1;
    endfunction

endpackage

// File: rtl/pd_control_if.sv
// Decoded-posit handshake bus: sign/scale/fraction with G/R/S, specials and
// frame markers on an rts/rtr handshake.
interface pd_control_if #(
    parameter int unsigned SCALE_WIDTH    = 7,
    parameter int unsigned FRACTION_WIDTH = 12
);
    logic                      rts;
    logic                      rtr;
    logic                      sow;
    logic                      eow;
    logic                      sign;
    logic [SCALE_WIDTH-1:0]    scale;
    logic [FRACTION_WIDTH-1:0] fraction;
    logic                      guard;
    logic                      round;
    logic                      sticky;
    logic                      nar;
    logic                      zero;

    modport master (
        output rts, sow, eow, sign, scale, fraction, guard, round, sticky, nar, zero,
        input  rtr
    );

    modport slave (
        input  rts, sow, eow, sign, scale, fraction, guard, round, sticky, nar, zero,
        output rtr
    );
endinterface

// File: rtl/posit_round_pack.sv
// Round-to-nearest-even of a left-aligned posit magnitude field to N-1 bits,
// with saturation so a nonzero value never becomes zero or NaR.
module posit_round_pack
    import posit_pkg::*;
#(
    parameter int unsigned POSIT_WIDTH = 16,
    parameter int unsigned FIELD_WIDTH = 43
) (
    input  logic [FIELD_WIDTH-1:0] field,
    input  logic                   sticky,
    input  logic                   sat_max,
    input  logic                   sat_min,
    output logic [POSIT_WIDTH-1:0] magnitude
);
    localparam int unsigned N = POSIT_WIDTH;

    logic [N-2:0] kept;
    logic         round_bit;
    logic         sticky_bit;
    logic         round_up;
    logic [N-1:0] sum;

    assign kept       = field[FIELD_WIDTH-1 -: N-1];
    assign round_bit  = field[FIELD_WIDTH-N];
    assign sticky_bit = sticky | (|field[FIELD_WIDTH-N-1:0]);
    assign round_up   = round_bit & (sticky_bit | kept[0]);
    assign sum        = {1'b0, kept} + {{(N-1){1'b0}}, round_up};

    always_comb begin
        if (sat_max || sum[N-1]) begin
            magnitude = N'(get_maxpos(N));
        end else if (sat_min || sum == '0) begin
            magnitude = N'(get_minpos());
        end else begin
            magnitude = sum;
        end
    end
endmodule

// File: rtl/posit_encoder_stream.sv
// Two-stage streaming posit encoder: S1 builds the regime/exponent/fraction
// field, S2 rounds, saturates and applies sign. Stages stall independently.
module posit_encoder_stream
    import posit_pkg::*;
#(
    parameter int unsigned POSIT_WIDTH = 16,
    parameter int unsigned POSIT_ES    = 1,
    parameter pd_type      PD_TYPE     = NORMAL
) (
    input  logic                   clk,
    input  logic                   rst,
    pd_control_if.slave            pd_in,
    output logic                   posit_rts,
    input  logic                   posit_rtr,
    output logic                   posit_sow,
    output logic                   posit_eow,
    output logic [POSIT_WIDTH-1:0] posit_data
);
    localparam int unsigned N       = POSIT_WIDTH;
    localparam int unsigned SW      = get_scale_width(PD_TYPE, N, POSIT_ES);
    localparam int unsigned FW      = get_fraction_width(PD_TYPE, N, POSIT_ES);
    localparam int unsigned FIELD_W = 2 * N + FW - 1;  // field without the sign bit
    localparam int unsigned TAIL_W  = POSIT_ES + FW + 2;
    localparam int unsigned PAD_W   = FIELD_W - 2 - TAIL_W;
    localparam logic signed [SW-1:0] MAX_SCALE = SW'(get_max_scale(N, POSIT_ES));

    logic signed [SW-1:0] scale_s;
    logic signed [SW-1:0] k;
    logic [SW-1:0]        shamt;
    logic [TAIL_W-1:0]    tail;
    logic [FIELD_W-1:0]   field;
    logic                 sat_max;
    logic                 sat_min;

    logic               s1_valid_q, s1_sign_q, s1_nar_q, s1_zero_q, s1_sow_q, s1_eow_q;
    logic               s1_sat_max_q, s1_sat_min_q, s1_sticky_q;
    logic [FIELD_W-1:0] s1_field_q;
    logic               s2_valid_q, s2_sow_q, s2_eow_q;
    logic [N-1:0]       s2_data_q;
    logic [N-1:0]       magnitude;
    logic [N-1:0]       s2_data_d;
    logic               s1_ready;
    logic               s2_ready;

    assign scale_s = $signed(pd_in.scale);
    assign k       = scale_s >>> POSIT_ES;
    assign shamt   = k[SW-1] ? -k : k;
    // Low es bits of scale are the exponent field.
    assign tail    = TAIL_W'({pd_in.scale, pd_in.fraction, pd_in.guard, pd_in.round});
    assign sat_max = scale_s >= MAX_SCALE;
    assign sat_min = scale_s <= -MAX_SCALE;

    // k >= 0: k+1 ones then 0 via sign-extending shift; k < 0: -k zeros then 1.
    always_comb begin
        if (k[SW-1]) begin
            field = {1'b1, tail, {PAD_W{1'b0}}, 1'b0} >> shamt;
        end else begin
            field = $signed({2'b10, tail, {PAD_W{1'b0}}}) >>> shamt;
        end
    end

    assign s2_ready  = !s2_valid_q || posit_rtr;
    assign s1_ready  = !s1_valid_q || s2_ready;
    assign pd_in.rtr = s1_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_nar_q     <= 1'b0;
            s1_zero_q    <= 1'b0;
            s1_sow_q     <= 1'b0;
            s1_eow_q     <= 1'b0;
            s1_sat_max_q <= 1'b0;
            s1_sat_min_q <= 1'b0;
            s1_sticky_q  <= 1'b0;
            s1_field_q   <= '0;
        end else if (s1_ready) begin
            s1_valid_q <= pd_in.rts;
            if (pd_in.rts) begin
                s1_sign_q    <= pd_in.sign;
                s1_nar_q     <= pd_in.nar;
                s1_zero_q    <= pd_in.zero;
                s1_sow_q     <= pd_in.sow;
                s1_eow_q     <= pd_in.eow;
                s1_sat_max_q <= sat_max;
                s1_sat_min_q <= sat_min;
                s1_sticky_q  <= pd_in.sticky;
                s1_field_q   <= field;
            end
        end
    end

    posit_round_pack #(
        .POSIT_WIDTH (N),
        .FIELD_WIDTH (FIELD_W)
    ) u_round_pack (
        .field     (s1_field_q),
        .sticky    (s1_sticky_q),
        .sat_max   (s1_sat_max_q),
        .sat_min   (s1_sat_min_q),
        .magnitude (magnitude)
    );

    always_comb begin
        if (s1_nar_q) begin
            s2_data_d = {1'b1, {(N-1){1'b0}}};
        end else if (s1_zero_q) begin
            s2_data_d = '0;
        end else if (s1_sign_q) begin
            s2_data_d = -magnitude;
        end else begin
            s2_data_d = magnitude;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_sow_q   <= 1'b0;
            s2_eow_q   <= 1'b0;
            s2_data_q  <= '0;
        end else if (s2_ready) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_sow_q  <= s1_sow_q;
                s2_eow_q  <= s1_eow_q;
                s2_data_q <= s2_data_d;
            end
        end
    end

    assign posit_rts  = s2_valid_q;
    assign posit_sow  = s2_sow_q;
    assign posit_eow  = s2_eow_q;
    assign posit_data = s2_data_q;
endmodule

// File: doc/posit_encoder_stream.md
# posit_encoder_stream

Streaming posit encoder. It is the consumer (slave) end of `pd_control_if`: it accepts decoded posit fields (sign, scale, fraction, guard/round/sticky, NaR, zero) with frame markers, and rounds and packs them into a `POSIT_WIDTH`-bit posit word. Results leave on an rts/rtr stream with `sow`/`eow` preserved. The block sits at the tail of every arithmetic datapath (adder, multiplier, quire-to-posit) that produces `pd_control_if` master traffic.

## Interface
Parameters:
- `POSIT_WIDTH`, 16, output posit width N (≥ 8).
- `POSIT_ES`, 1, exponent field width es (0..3).
- `PD_TYPE`, NORMAL, selects `scale_width`/`fraction_width` of the input interface via the package functions.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pd_in`  `pd_control_if.slave`  –  decoded input. `fraction` excludes the hidden bit.
- `posit_rts`  out  1  output word valid.
- `posit_rtr`  in  1  downstream ready.
- `posit_sow`  out  1  start-of-word-stream marker, aligned with data.
- `posit_eow`  out  1  end marker, aligned with data.
- `posit_data`  out  N  encoded posit.

## Operation
- **Input transfer:** occurs when `pd_in.rts && pd_in.rtr`.
- **Special values:**
  - `NaR` → `1` followed by N-1 zeros. NaR has priority over `zero`.
  - `zero` → all zeros.
  - Both ignore sign, scale, and fraction.
- **Field extraction:**
  - k = `scale` >>> es (arithmetic shift).
  - e = `scale[es-1:0]`.
- **Regime:**
  - k ≥ 0 → k+1 ones followed by a zero.
  - k < 0 → −k zeros followed by a one.
- **Packing:** build {0, regime, e, fraction, guard, round, sticky} in a (2N + fraction_width) bit field, then truncate to N bits.
  - LSB = last kept bit.
  - Round bit = first dropped bit.
  - Sticky = OR of the remaining dropped bits and the input `guard`/`round`/`sticky`, as applicable.
- **Rounding:** round-to-nearest-even on the N-1 magnitude bits. Carry may ripple into the exponent or regime; this is legal in posit encoding.
- **Saturation:**
  - Scale ≥ maxscale = (N-2)·2^es → magnitude 0x7F..F (maxpos).
  - Scale ≤ −maxscale → magnitude 0x0..01 (minpos).
  - A nonzero input never encodes to zero or NaR. Rounding never produces magnitude 0 or 2^(N-1).
- **Sign:** if `sign`, output = two's complement of the magnitude.
- **Markers:** `sow`/`eow` travel unchanged alongside their word.

## Timing
- Two-stage pipeline. Latency is exactly 2 cycles from input transfer to `posit_rts` when there is no backpressure.
  - S1 registers: k, e, shifted field, special flags, sign, markers.
  - S2 registers: the rounded and signed word.
- Throughput is 1 word/cycle.
- **Stall rule:** each stage holds when it is valid and the next stage cannot accept. Use standard per-stage valid with ready = !valid_next || ready_next, so there are no bubbles.
- `pd_in.rtr` = !s1_valid || s2_accepts. It depends combinationally on `posit_rtr` (no skid buffer).
- **Output stability:** while `posit_rts && !posit_rtr`, `posit_data`, `posit_sow`, and `posit_eow` stay stable.
- **Reset:**
  - All valids clear. `posit_rts`=0, `posit_data`=0, `posit_sow`=0, `posit_eow`=0.
  - `pd_in.rtr` reads 1 one combinational delay after reset deassert, since the stages are empty.
  - In-flight words are discarded on reset mid-operation. No partial output may appear after reset.
- **Simultaneous events:** input transfer and output transfer in the same cycle with the pipeline full is lossless and keeps occupancy at 2.

## Structure
- Shared package `posit_pkg` holds `pd_type`, `get_scale_width`, `get_fraction_width`, plus new functions `get_max_scale(N, es)` and `get_maxpos`/`get_minpos` magnitude constants.
- One combinational sub-module, `posit_round_pack`: field + G/R/S in, rounded magnitude out, with saturation. S2 instantiates it, and the posit adder will reuse it.

## Test plan
N=16, es=1, PD_TYPE=NORMAL, fraction zero unless stated.
1. scale=0 → 0x4000. scale=1 → 0x5000. scale=−1 → 0x3000. With sign=1 and scale=0 → 0xC000. Each output appears 2 cycles after transfer.
2. scale=28 → 0x7FFF and scale=40 → 0x7FFF. scale=−28 → 0x0001 and scale=−40 → 0x0001. The sign=1 version of scale=40 → 0x8001.
3. Rounding, all at scale=0:
   - Fraction all ones with guard=1 → 0x5000 (carry into exponent).
   - Kept LSB=0, round bit=1, sticky=0 → round down (tie-to-even).
   - The same with sticky=1 → round up.
4. NaR=1 with zero=1 → 0x8000. zero=1 with sign=1 → 0x0000.
5. Backpressure:
   - Stream 6 words with sow on the first and eow on the last.
   - Hold `posit_rtr`=0 for 5 cycles mid-stream. `pd_in.rtr` must drop after 2 words are buffered.
   - Output order, values, and markers must be preserved, with no duplicates, and data stable while stalled.
6. Assert `rst` for 1 cycle with 2 words in flight. `posit_rts` goes 0 immediately and stays 0 until new input arrives. The next word then emerges 2 cycles after its transfer.
